// File: rtl/copperv_bus_pkg.sv
// Shared types and defaults for the copperv memory bus.
// Monitors and bus models reuse these so field widths stay consistent.
package copperv_bus_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        SRC_IR = 1'b0,
        SRC_DR = 1'b1
    } rd_src_t;

endpackage

// File: rtl/copperv_tag_fifo.sv
// Small synchronous FIFO for tracking transaction tags in request order.
// Writes when full and reads when empty are ignored.
module copperv_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage is not reset; only pointers and occupancy matter.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/copperv_read_arbiter.sv
// Shares one memory read port between the instruction and data read channels.
// Round-robin address arbitration with grant lock; in-order responses routed by tag.
module copperv_read_arbiter
    import copperv_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ir_addr_valid,
    output logic                              ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0]             ir_addr,
    output logic                              ir_data_valid,
    input  logic                              ir_data_ready,
    output logic [DATA_WIDTH-1:0]             ir_data,
    input  logic                              dr_addr_valid,
    output logic                              dr_addr_ready,
    input  logic [ADDR_WIDTH-1:0]             dr_addr,
    output logic                              dr_data_valid,
    input  logic                              dr_data_ready,
    output logic [DATA_WIDTH-1:0]             dr_data,
    output logic                              mem_addr_valid,
    input  logic                              mem_addr_ready,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic                              mem_data_valid,
    output logic                              mem_data_ready,
    input  logic [DATA_WIDTH-1:0]             mem_data,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_unexpected_resp
);

    rd_src_t sel;
    rd_src_t lock_src_q;
    rd_src_t last_grant_q;
    rd_src_t head_src;
    logic    lock_q;
    logic    err_q;
    logic    sel_valid;
    logic    push;
    logic    pop;
    logic    full;
    logic    empty;
    logic    push_tag;
    logic    head_tag;

    always_comb begin
        sel = SRC_IR;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (ir_addr_valid && !dr_addr_valid) begin
            sel = SRC_IR;
        end else if (dr_addr_valid && !ir_addr_valid) begin
            sel = SRC_DR;
        end else if (ir_addr_valid && dr_addr_valid) begin
            sel = (last_grant_q == SRC_DR) ? SRC_IR : SRC_DR;
        end
    end

    assign sel_valid      = (sel == SRC_DR) ? dr_addr_valid : ir_addr_valid;
    assign mem_addr_valid = !rst && sel_valid && !full;
    assign mem_addr       = (sel == SRC_DR) ? dr_addr : ir_addr;
    assign ir_addr_ready  = mem_addr_valid && mem_addr_ready && (sel == SRC_IR);
    assign dr_addr_ready  = mem_addr_valid && mem_addr_ready && (sel == SRC_DR);
    assign push           = mem_addr_valid && mem_addr_ready;
    assign push_tag       = sel;

    // Tags pushed this cycle are not visible to routing until the next one.
    assign head_src = rd_src_t'(head_tag);

    always_comb begin
        ir_data_valid  = 1'b0;
        dr_data_valid  = 1'b0;
        mem_data_ready = 1'b0;
        if (!rst && !empty) begin
            if (head_src == SRC_IR) begin
                ir_data_valid  = mem_data_valid;
                mem_data_ready = ir_data_ready;
            end else begin
                dr_data_valid  = mem_data_valid;
                mem_data_ready = dr_data_ready;
            end
        end
    end

    assign pop                 = mem_data_valid && mem_data_ready;
    assign ir_data             = mem_data;
    assign dr_data             = mem_data;
    assign err_unexpected_resp = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_src_q   <= SRC_IR;
            last_grant_q <= SRC_DR;
            err_q        <= 1'b0;
        end else begin
            if (push) begin
                lock_q       <= 1'b0;
                last_grant_q <= sel;
            end else if (mem_addr_valid) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end
            if (mem_data_valid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    copperv_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_tag),
        .dout  (head_tag),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_copperv_read_arbiter.sv
// Directed bench for copperv_read_arbiter: queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_copperv_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ir_addr_valid = 1'b0;
    logic          ir_addr_ready;
    logic [AW-1:0] ir_addr = '0;
    logic          ir_data_valid;
    logic          ir_data_ready = 1'b1;
    logic [DW-1:0] ir_data;
    logic          dr_addr_valid = 1'b0;
    logic          dr_addr_ready;
    logic [AW-1:0] dr_addr = '0;
    logic          dr_data_valid;
    logic          dr_data_ready = 1'b1;
    logic [DW-1:0] dr_data;
    logic          mem_addr_valid;
    logic          mem_addr_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_data_valid = 1'b0;
    logic          mem_data_ready;
    logic [DW-1:0] mem_data = '0;
    logic [2:0]    outstanding;
    logic          err_unexpected_resp;

    copperv_read_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ir_addr_valid       (ir_addr_valid),
        .ir_addr_ready       (ir_addr_ready),
        .ir_addr             (ir_addr),
        .ir_data_valid       (ir_data_valid),
        .ir_data_ready       (ir_data_ready),
        .ir_data             (ir_data),
        .dr_addr_valid       (dr_addr_valid),
        .dr_addr_ready       (dr_addr_ready),
        .dr_addr             (dr_addr),
        .dr_data_valid       (dr_data_valid),
        .dr_data_ready       (dr_data_ready),
        .dr_data             (dr_data),
        .mem_addr_valid      (mem_addr_valid),
        .mem_addr_ready      (mem_addr_ready),
        .mem_addr            (mem_addr),
        .mem_data_valid      (mem_data_valid),
        .mem_data_ready      (mem_data_ready),
        .mem_data            (mem_data),
        .outstanding         (outstanding),
        .err_unexpected_resp (err_unexpected_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owners of outstanding requests in order (0=IR, 1=DR).
    int q[$];
    int last_grant = 1;
    int held       = -1;
    bit m_err      = 1'b0;

    int e_sel;
    bit e_mav, e_irr, e_drr, e_irdv, e_drdv, e_mdr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit full;
        full = (q.size() == MO);
        if (held >= 0) e_sel = held;
        else if (ir_addr_valid && !dr_addr_valid) e_sel = 0;
        else if (dr_addr_valid && !ir_addr_valid) e_sel = 1;
        else if (ir_addr_valid && dr_addr_valid) e_sel = 1 - last_grant;
        else e_sel = -1;
        e_mav  = (e_sel >= 0) && !full;
        e_irr  = e_mav && mem_addr_ready && (e_sel == 0);
        e_drr  = e_mav && mem_addr_ready && (e_sel == 1);
        e_irdv = 1'b0;
        e_drdv = 1'b0;
        e_mdr  = 1'b0;
        if (q.size() > 0) begin
            if (q[0] == 0) begin
                e_irdv = mem_data_valid;
                e_mdr  = ir_data_ready;
            end else begin
                e_drdv = mem_data_valid;
                e_mdr  = dr_data_ready;
            end
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        model_eval();
        chk("mem_addr_valid", mem_addr_valid, e_mav);
        chk("ir_addr_ready", ir_addr_ready, e_irr);
        chk("dr_addr_ready", dr_addr_ready, e_drr);
        chk("ir_data_valid", ir_data_valid, e_irdv);
        chk("dr_data_valid", dr_data_valid, e_drdv);
        chk("mem_data_ready", mem_data_ready, e_mdr);
        chk("outstanding", outstanding, q.size());
        chk("err_unexpected_resp", err_unexpected_resp, m_err);
        if (e_mav) chk("mem_addr", mem_addr, (e_sel == 1) ? dr_addr : ir_addr);
        if (e_irdv) chk("ir_data", ir_data, mem_data);
        if (e_drdv) chk("dr_data", dr_data, mem_data);
    endtask

    task automatic tick_adv();
        bit popped, pushed;
        @(posedge clk);
        popped = mem_data_valid && e_mdr;
        pushed = e_mav && mem_addr_ready;
        if (mem_data_valid && q.size() == 0) m_err = 1'b1;
        if (popped) void'(q.pop_front());
        if (pushed) begin
            q.push_back(e_sel);
            last_grant = e_sel;
            held = -1;
        end else if (e_mav) begin
            held = e_sel;
        end
        #1;
    endtask

    task automatic step();
        tick_check();
        tick_adv();
    endtask

    // Asserts reset between edges with whatever stimulus is live, checks the
    // forced-idle outputs, then releases reset just after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mem_addr_valid", mem_addr_valid, 1'b0);
        chk("rst_ir_addr_ready", ir_addr_ready, 1'b0);
        chk("rst_dr_addr_ready", dr_addr_ready, 1'b0);
        chk("rst_ir_data_valid", ir_data_valid, 1'b0);
        chk("rst_dr_data_valid", dr_data_valid, 1'b0);
        chk("rst_mem_data_ready", mem_data_ready, 1'b0);
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_err", err_unexpected_resp, 1'b0);
        ir_addr_valid  = 1'b0;
        dr_addr_valid  = 1'b0;
        mem_data_valid = 1'b0;
        mem_addr_ready = 1'b0;
        ir_data_ready  = 1'b1;
        dr_data_ready  = 1'b1;
        q.delete();
        last_grant = 1;
        held       = -1;
        m_err      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Live stimulus during the first reset to exercise output forcing.
        ir_addr_valid  = 1'b1;
        dr_addr_valid  = 1'b1;
        mem_addr_ready = 1'b1;
        mem_data_valid = 1'b1;
        do_reset();

        // Single IR request and its response.
        ir_addr_valid = 1'b1; ir_addr = 32'h0000_0010; mem_addr_ready = 1'b1;
        tick_check();
        chk("t1_ir_ready", ir_addr_ready, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h0000_0010);
        chk("t1_out0", outstanding, 3'd0);
        tick_adv();
        ir_addr_valid = 1'b0; mem_data_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick_check();
        chk("t1_ir_dv", ir_data_valid, 1'b1);
        chk("t1_ir_data", ir_data, 32'hDEAD_BEEF);
        chk("t1_dr_dv", dr_data_valid, 1'b0);
        chk("t1_out1", outstanding, 3'd1);
        tick_adv();
        mem_data_valid = 1'b0;
        tick_check();
        chk("t1_out_back0", outstanding, 3'd0);
        tick_adv();

        // Both requesters always valid: IR first, then alternate until full.
        do_reset();
        ir_addr_valid = 1'b1; ir_addr = 32'h100;
        dr_addr_valid = 1'b1; dr_addr = 32'h200;
        mem_addr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_check();
            chk("t2_ir_grant", ir_addr_ready, (i % 2) == 0);
            chk("t2_dr_grant", dr_addr_ready, (i % 2) == 1);
            chk("t2_mem_addr", mem_addr, (i % 2 == 1) ? 32'h200 : 32'h100);
            tick_adv();
        end
        tick_check();
        chk("t2_full_mav", mem_addr_valid, 1'b0);
        chk("t2_full_out", outstanding, 3'd4);
        tick_adv();
        ir_addr_valid = 1'b0; dr_addr_valid = 1'b0;
        mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_data = 32'hA0 + i;
            tick_check();
            chk("t2_route_ir", ir_data_valid, (i % 2) == 0);
            chk("t2_route_dr", dr_data_valid, (i % 2) == 1);
            tick_adv();
        end
        mem_data_valid = 1'b0;

        // Lock: DR stalled three cycles, IR joins in the second.
        dr_addr_valid = 1'b1; dr_addr = 32'h2000; mem_addr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                ir_addr_valid = 1'b1; ir_addr = 32'h3000;
            end
            tick_check();
            chk("t3_mav", mem_addr_valid, 1'b1);
            chk("t3_mem_addr", mem_addr, 32'h2000);
            chk("t3_ir_ready", ir_addr_ready, 1'b0);
            tick_adv();
        end
        mem_addr_ready = 1'b1;
        tick_check();
        chk("t3_dr_hs", dr_addr_ready, 1'b1);
        chk("t3_ir_wait", ir_addr_ready, 1'b0);
        tick_adv();
        dr_addr_valid = 1'b0;
        tick_check();
        chk("t3_ir_hs", ir_addr_ready, 1'b1);
        chk("t3_ir_addr", mem_addr, 32'h3000);
        tick_adv();
        ir_addr_valid = 1'b0;
        mem_data_valid = 1'b1; mem_data = 32'h55;
        step();
        step();
        mem_data_valid = 1'b0;

        // Fill to MAX_OUTSTANDING; pop on the full cycle still blocks the grant.
        ir_addr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ir_addr = 32'h40 + 4 * i;
            step();
        end
        ir_addr = 32'h50;
        mem_data_valid = 1'b1; mem_data = 32'h1;
        tick_check();
        chk("t4_out_full", outstanding, 3'd4);
        chk("t4_blocked_ready", ir_addr_ready, 1'b0);
        chk("t4_blocked_mav", mem_addr_valid, 1'b0);
        chk("t4_pop_ready", mem_data_ready, 1'b1);
        tick_adv();
        mem_data_valid = 1'b0;
        tick_check();
        chk("t4_resume", ir_addr_ready, 1'b1);
        chk("t4_out3", outstanding, 3'd3);
        tick_adv();
        ir_addr_valid = 1'b0;
        mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_data = 32'h60 + i;
            step();
        end
        mem_data_valid = 1'b0;

        // Response backpressure: DR at head, IR queued behind it.
        dr_addr_valid = 1'b1; dr_addr = 32'h500;
        step();
        dr_addr_valid = 1'b0; ir_addr_valid = 1'b1; ir_addr = 32'h600;
        step();
        ir_addr_valid = 1'b0;
        mem_data_valid = 1'b1; mem_data = 32'h77; dr_data_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick_check();
            chk("t6_mdr_held", mem_data_ready, 1'b0);
            chk("t6_dr_dv", dr_data_valid, 1'b1);
            chk("t6_ir_not_early", ir_data_valid, 1'b0);
            tick_adv();
        end
        dr_data_ready = 1'b1;
        step();
        mem_data = 32'h78;
        tick_check();
        chk("t6_ir_after", ir_data_valid, 1'b1);
        tick_adv();
        mem_data_valid = 1'b0;

        // Unexpected response sets the sticky error; reset clears everything.
        mem_data_valid = 1'b1; mem_data = 32'h99;
        tick_check();
        chk("t5_unexp_ready", mem_data_ready, 1'b0);
        chk("t5_err_before", err_unexpected_resp, 1'b0);
        tick_adv();
        mem_data_valid = 1'b0;
        tick_check();
        chk("t5_err_set", err_unexpected_resp, 1'b1);
        tick_adv();
        ir_addr_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ir_addr = 32'h800 + 4 * i;
            step();
        end
        dr_addr_valid = 1'b1; dr_addr = 32'h900;
        tick_check();
        chk("t5_err_sticky", err_unexpected_resp, 1'b1);
        chk("t5_out2", outstanding, 3'd2);
        mem_data_valid = 1'b1;
        do_reset();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/copperv_read_arbiter.md
Name: copperv_read_arbiter

Overview:
- Shares one memory read port between the copperv instruction-read channel (ir_*) and data-read channel (dr_*).
- Arbitrates the address channel round-robin with grant lock.
- Records the source of every accepted request in a tag FIFO and routes in-order read responses back to the owner.
- Sits between the CPU core and the unified memory model / bus bridge.

Parameters:
- ADDR_WIDTH, 32, width of ir_addr, dr_addr, mem_addr
- DATA_WIDTH, 32, width of ir_data, dr_data, mem_data
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, >=2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ir_addr_valid  in  1  instruction read request
- ir_addr_ready  out  1  instruction request accepted
- ir_addr  in  ADDR_WIDTH  instruction address
- ir_data_valid  out  1  instruction response valid
- ir_data_ready  in  1  core accepts instruction response
- ir_data  out  DATA_WIDTH  instruction response data
- dr_addr_valid  in  1  data read request
- dr_addr_ready  out  1  data request accepted
- dr_addr  in  ADDR_WIDTH  data address
- dr_data_valid  out  1  data response valid
- dr_data_ready  in  1  core accepts data response
- dr_data  out  DATA_WIDTH  data response
- mem_addr_valid  out  1  request to memory
- mem_addr_ready  in  1  memory accepts request
- mem_addr  out  ADDR_WIDTH  muxed address
- mem_data_valid  in  1  memory response valid
- mem_data_ready  out  1  arbiter accepts response
- mem_data  in  DATA_WIDTH  memory response data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  tag FIFO occupancy
- err_unexpected_resp  out  1  sticky: response with no outstanding request

Behaviour:
- Reset (async): tag FIFO empty, outstanding=0, lock=0, last_grant=DR (so IR wins the first tie), err_unexpected_resp=0.
- While rst=1: every valid/ready output is forced to 0.
- Handshake: a transfer occurs when valid && ready are both high at a rising edge.
- Requesters must hold valid and address stable until accepted. The arbiter relies on this rule and does not check it.
- Address channel, combinational:
  - sel = locked source if lock=1.
  - Otherwise, if only one requester is valid, sel is that requester.
  - Otherwise, if both are valid, sel is the source not equal to last_grant.
  - mem_addr_valid = sel's valid && !full.
  - mem_addr = sel's address.
  - Granted requester's addr_ready = mem_addr_ready && !full.
  - The other requester's addr_ready = 0.
- Zero-latency pass-through; no added register stage on the address path.
- Lock:
  - Set when mem_addr_valid && !mem_addr_ready. The grant is held until the handshake completes.
  - Cleared on handshake.
  - Guarantees mem_addr_valid never drops and mem_addr is stable while waiting.
- last_grant updates to sel on each address handshake only.
- Tag FIFO:
  - Push sel (0=IR, 1=DR) on each mem address handshake.
  - Pop on each mem data handshake.
  - full = (outstanding == MAX_OUTSTANDING). While full, no grant: mem_addr_valid=0 and both addr_ready=0, even if a pop happens the same cycle.
  - Simultaneous push and pop when not full leaves outstanding unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing, combinational:
  - If FIFO is non-empty: head=IR gives ir_data_valid = mem_data_valid and mem_data_ready = ir_data_ready; head=DR does the same on the dr side.
  - Non-selected data_valid = 0.
  - ir_data and dr_data both carry mem_data (qualify with valid).
  - Responses return strictly in request order. No reordering support.
- Empty FIFO with mem_data_valid=1:
  - mem_data_ready=0 and both data_valid=0.
  - err_unexpected_resp sets at that edge and stays set until reset.
- Same-cycle request and response on an empty FIFO: the response is still unexpected; pushed tags are visible to routing only from the next cycle.
- Reset mid-operation discards all outstanding tags. The memory side must be reset together with the arbiter.

Decomposition:
- Package copperv_bus_pkg:
  - typedef enum logic {SRC_IR=0, SRC_DR=1} rd_src_t
  - localparam for default ADDR/DATA widths, reused by monitors and bus models.
- Sub-module copperv_tag_fifo:
  - Parameterized depth and width.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-high reset.
  - Reusable for the write-response path later.

Test Plan:
- Single IR request addr 0x0000_0010, mem_addr_ready=1, mem_data=0xDEAD_BEEF next cycle -> ir_addr_ready=1 same cycle, ir_data_valid=1 with 0xDEAD_BEEF, dr_data_valid stays 0, outstanding 0->1->0.
- Both valid every cycle (IR 0x100, DR 0x200), mem always ready -> first grant IR after reset, then alternating IR, DR, IR, DR; responses routed in that order.
- DR 0x2000 valid with mem_addr_ready=0 for 3 cycles while IR raises valid in cycle 2 -> mem_addr holds 0x2000 stable and valid for all 3 cycles, IR not granted until after the DR handshake.
- 4 IR requests accepted with no responses (MAX_OUTSTANDING=4) -> outstanding=4, 5th request sees ir_addr_ready=0 and mem_addr_valid=0. After one response and the following cycle -> grant resumes.
- mem_data_valid=1 with empty FIFO -> mem_data_ready=0, err_unexpected_resp=1 next edge and remains 1. rst pulse mid-burst with 2 outstanding -> outstanding=0, err cleared, all valids 0 asynchronously.
- Response backpressure: head=DR, dr_data_ready=0 for 2 cycles -> mem_data_ready=0 for those cycles, IR responses behind it are not delivered early.
